layer_4_featuremap_packer: RTL and testbench

//  Producer end of the 32-channel feature-map stream consumed by the layer_4 featuremap blocks.
//  - Accepts the previous layer's output as a channel-serial 32-bit stream (ch0..chN-1 per

---
 rtl/layer_4_featuremap_packer.sv | 136 +++++++++++++
 tb/tb_layer_4_featuremap_packer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_4_featuremap_packer.sv
// Packs a channel-serial word stream into one NUM_CH-wide beat per pixel.
// Framing is checked against in_last; it is reported through a sticky err_len flag.
module layer_4_featuremap_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 32,
  parameter int IMG_SIZE   = 104,
  localparam int OUT_WIDTH = DATA_WIDTH * NUM_CH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic                  valid_out,
  output logic                  sof,
  output logic                  eof,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(IMG_SIZE - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                             state_q, state_d;
  logic [CW-1:0]                      ch_q, ch_d;
  logic [IW-1:0]                      col_q, col_d, row_q, row_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  pack_q, pack_d;
  logic [OUT_WIDTH-1:0]               data_q, data_d;
  logic                               valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic                               done_q, done_d, err_q, err_d;
  logic                               lane_last, pix_first, pix_last;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    col_d     = col_q;
    row_d     = row_q;
    pack_d    = pack_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    lane_last = (ch_q == CH_LAST);
    pix_first = (row_q == '0) && (col_q == '0);
    pix_last  = (row_q == IDX_LAST) && (col_q == IDX_LAST);
    unique case (state_q)
      IDLE: if (start) begin
        state_d = STREAM;
        ch_d    = '0;
        col_d   = '0;
        row_d   = '0;
        err_d   = 1'b0;
      end
      STREAM: if (in_valid) begin
        pack_d[ch_q] = in_data;
        if (lane_last) begin
          // pack_d already holds the final lane, so the beat is complete here
          ch_d    = '0;
          data_d  = pack_d;
          valid_d = 1'b1;
          sof_d   = pix_first;
          eof_d   = pix_last;
          if (col_q == IDX_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          ch_d = ch_q + 1'b1;
        end
        if (lane_last && pix_last) begin
          state_d = DONE;
          err_d   = err_q | ~in_last;
        end else if (in_last) begin
          // early end: any partial pixel in pack_q is simply never emitted
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pack_q  <= pack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == STREAM);
  assign busy      = (state_q != IDLE);
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign done      = done_q;
  assign err_len   = err_q;

endmodule

// File: tb/tb_layer_4_featuremap_packer.sv
// Directed bench: small 4ch/2x2 instance for framing cases, 32ch instance for a long frame.
module tb_layer_4_featuremap_packer;

  localparam int BIMG = 12;
  localparam int BPIX = BIMG * BIMG;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         start, in_valid, in_last;
  logic [31:0]  in_data;
  logic         in_ready, valid_out, sof, eof, busy, done, err_len;
  logic [127:0] data_out;

  logic          b_start, b_valid, b_last;
  logic [31:0]   b_data;
  logic          b_ready, b_valid_out, b_sof, b_eof, b_busy, b_done, b_err;
  logic [1023:0] b_data_out;

  always #5 Clk = ~Clk;

  layer_4_featuremap_packer #(.DATA_WIDTH(32), .NUM_CH(4), .IMG_SIZE(2)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .data_out(data_out), .valid_out(valid_out),
    .sof(sof), .eof(eof), .busy(busy), .done(done), .err_len(err_len));

  layer_4_featuremap_packer #(.DATA_WIDTH(32), .NUM_CH(32), .IMG_SIZE(BIMG)) dut_big (
    .Clk(Clk), .Rst(Rst), .start(b_start), .in_data(b_data), .in_valid(b_valid),
    .in_last(b_last), .in_ready(b_ready), .data_out(b_data_out), .valid_out(b_valid_out),
    .sof(b_sof), .eof(b_eof), .busy(b_busy), .done(b_done), .err_len(b_err));

  int n_tot = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] d;
    logic         s;
    logic         e;
    int           c;
  } pix_t;

  pix_t pq[$];
  int   dq[$];
  int   vq[$];
  int   bpix = 0;
  int   bdone = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (valid_out) pq.push_back('{data_out, sof, eof, cyc});
    if (done) dq.push_back(cyc);
  end

  always @(negedge Clk) begin
    logic [1023:0] e;
    if (b_valid_out) begin
      for (int c = 0; c < 32; c++) e[c*32 +: 32] = 32'(bpix * 32 + c);
      chk("big_data", b_data_out, e);
      chk("big_sof", b_sof, bpix == 0);
      chk("big_eof", b_eof, bpix == BPIX - 1);
      bpix++;
    end
    if (b_done) bdone++;
  end

  task automatic clr();
    pq.delete();
    dq.delete();
    vq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  // word index i is 1-based within the frame; lane-3 acceptance cycles are logged
  task automatic send(input logic [31:0] d, input logic last, input int gap, input int i);
    idle(gap);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge Clk); #1;
    if (i % 4 == 0) vq.push_back(cyc);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_frame(input string t, input int base, input int npix, input bit full);
    logic [127:0] e;
    chk({t, "_npix"}, pq.size(), npix);
    for (int p = 0; p < npix && p < pq.size(); p++) begin
      for (int c = 0; c < 4; c++) e[c*32 +: 32] = 32'(base + 4 * p + c);
      chk({t, "_data"}, pq[p].d, e);
      chk({t, "_sof"}, pq[p].s, p == 0);
      chk({t, "_eof"}, pq[p].e, full && (p == 3));
    end
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_last = 1'b0; b_data = '0;
    idle(3);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_err", err_len, 0);
    chk("rst_done", done, 0);
    chk("rst_sofeof", {sof, eof}, 0);
    @(posedge Clk); #1;

    // 1: back-to-back full frame
    clr();
    do_start();
    @(negedge Clk);
    chk("t1_busy", busy, 1);
    chk("t1_ready", in_ready, 1);
    for (int i = 1; i <= 16; i++) send(i, i == 16, 0, i);
    idle(4);
    chk_frame("t1", 1, 4, 1);
    chk("t1_ndone", dq.size(), 1);
    if (dq.size() == 1 && pq.size() == 4) chk("t1_done_cyc", dq[0], pq[3].c + 1);
    chk("t1_err", err_len, 0);
    chk("t1_hold", data_out, {32'd16, 32'd15, 32'd14, 32'd13});
    chk("t1_idle", {busy, in_ready}, 0);

    // 2: random gaps
    clr();
    do_start();
    for (int i = 1; i <= 16; i++) send(i, i == 16, $urandom_range(0, 3), i);
    idle(4);
    chk_frame("t2", 1, 4, 1);
    for (int p = 0; p < 4 && p < pq.size() && p < vq.size(); p++)
      chk("t2_lat", pq[p].c, vq[p]);
    chk("t2_err", err_len, 0);

    // 3: early in_last on word 6
    clr();
    do_start();
    for (int i = 1; i <= 6; i++) send(i, i == 6, 0, i);
    idle(4);
    chk_frame("t3", 1, 1, 0);
    chk("t3_err", err_len, 1);
    chk("t3_ndone", dq.size(), 1);
    chk("t3_ready", in_ready, 0);
    chk("t3_busy", busy, 0);

    // 4: in_last never asserted; next start clears err_len
    clr();
    do_start();
    for (int i = 1; i <= 16; i++) send(i, 1'b0, 0, i);
    idle(4);
    chk_frame("t4", 1, 4, 1);
    chk("t4_err", err_len, 1);
    chk("t4_ndone", dq.size(), 1);
    clr();
    do_start();
    @(negedge Clk);
    chk("t4_errclr", err_len, 0);
    for (int i = 1; i <= 16; i++) send(100 + i, i == 16, 0, i);
    idle(4);
    chk_frame("t4b", 101, 4, 1);
    chk("t4b_err", err_len, 0);

    // 5: reset mid-frame after word 9
    clr();
    do_start();
    for (int i = 1; i <= 9; i++) send(i, 1'b0, 0, i);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("t5_valid", valid_out, 0);
    chk("t5_data", data_out, 0);
    chk("t5_busy", {busy, in_ready}, 0);
    chk("t5_flags", {sof, eof, done, err_len}, 0);
    @(posedge Clk); #1;
    clr();
    do_start();
    for (int i = 1; i <= 16; i++) send(200 + i, i == 16, 0, i);
    idle(4);
    chk_frame("t5", 201, 4, 1);
    chk("t5_err", err_len, 0);

    // 6: 32-channel instance, incrementing words
    b_start = 1'b1;
    @(posedge Clk); #1;
    b_start = 1'b0;
    for (int p = 0; p < BPIX; p++)
      for (int c = 0; c < 32; c++) begin
        b_valid = 1'b1;
        b_data  = 32'(p * 32 + c);
        b_last  = (p == BPIX - 1) && (c == 31);
        @(posedge Clk); #1;
      end
    b_valid = 1'b0;
    b_last  = 1'b0;
    idle(4);
    chk("big_npix", bpix, BPIX);
    chk("big_ndone", bdone, 1);
    chk("big_err", b_err, 0);
    chk("big_idle", {b_busy, b_ready}, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
